// File: rtl/mlp_run_sequencer_if.sv
// Command / mlp_top side bundle for mlp_run_sequencer.
// slave  : the sequencer (consumes commands, drives the mlp_top controls)
// master : the host / environment side
`timescale 1ns/1ps
interface mlp_run_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        wf_push_col0;
  logic        wf_push_col1;
  logic [7:0]  wf_data_in;
  logic        wf_reset;
  logic        init_act_valid;
  logic [15:0] init_act_data;
  logic        start_mlp;
  logic        weights_ready;
  logic [3:0]  mlp_state;
  logic        layer_complete;
  logic        busy;
  logic        done;
  logic        err_order;
  logic        err_timeout;
  logic [15:0] run_cycles;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, mlp_state, layer_complete,
    output cmd_ready, wf_push_col0, wf_push_col1, wf_data_in, wf_reset,
           init_act_valid, init_act_data, start_mlp, weights_ready,
           busy, done, err_order, err_timeout, run_cycles
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, mlp_state, layer_complete,
    input  cmd_ready, wf_push_col0, wf_push_col1, wf_data_in, wf_reset,
           init_act_valid, init_act_data, start_mlp, weights_ready,
           busy, done, err_order, err_timeout, run_cycles
  );
endinterface

// File: rtl/mlp_run_sequencer.sv
// Host-side command sequencer that loads weights/activations into mlp_top,
// launches one inference and reports done / order errors / timeout.
// Optional feature macro: MLP_SEQ_PERF_CNT_EN (start-to-completion cycle
// counter on run_cycles; when undefined run_cycles is tied to 0).
`timescale 1ns/1ps
module mlp_run_sequencer #(
  parameter int WEIGHTS_PER_COL = 2,
  parameter int MAX_ACT         = 8,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  mlp_run_sequencer_if.slave bus
);
  localparam int WCW = $clog2(WEIGHTS_PER_COL + 1);
  localparam int ACW = $clog2(MAX_ACT + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] W_FULL  = WCW'(WEIGHTS_PER_COL);
  localparam logic [ACW-1:0] A_FULL  = ACW'(MAX_ACT);
  localparam logic [TCW-1:0] T_LIMIT = TCW'(TIMEOUT_CYCLES);

  localparam logic [1:0] OP_WEIGHT = 2'd0;
  localparam logic [1:0] OP_ACT    = 2'd1;
  localparam logic [1:0] OP_RUN    = 2'd2;
  localparam logic [1:0] OP_FLUSH  = 2'd3;
  localparam logic [3:0] MLP_IDLE  = 4'd0;
  localparam logic [3:0] MLP_LOAD  = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_CPL, S_WAIT_IDLE, S_ERR
  } state_t;

  state_t r_state, w_state_next;

  // registered outputs and bookkeeping
  logic           r_cmd_ready, r_push0, r_push1, r_wf_reset, r_act_valid;
  logic           r_start, r_weights_ready, r_busy, r_done, r_err_order, r_err_timeout;
  logic [7:0]     r_wf_data;
  logic [15:0]    r_act_data;
  logic [WCW-1:0] r_wcnt0, r_wcnt1;
  logic [ACW-1:0] r_act_cnt;
  logic [TCW-1:0] r_wait_cnt;
  logic           r_lc_d;

  // next-cycle values
  logic           w_cmd_ready, w_push0, w_push1, w_wf_reset, w_act_valid;
  logic           w_start, w_weights_ready, w_busy, w_done, w_err_order, w_err_timeout;
  logic [7:0]     w_wf_data;
  logic [15:0]    w_act_data;
  logic [WCW-1:0] w_wcnt0, w_wcnt1;
  logic [ACW-1:0] w_act_cnt;
  logic [TCW-1:0] w_wait_cnt;

  // command decode: an accepted command is legal, a flush, or dropped
  logic w_accept, w_in_idle, w_col, w_col_full, w_weights_full;
  logic w_weight_ok, w_act_ok, w_run_ok, w_flush, w_drop;
  logic w_lc_rise, w_timeout;
  logic [TCW-1:0] w_wait_inc;

  assign w_accept       = bus.cmd_valid & r_cmd_ready;
  assign w_in_idle      = (r_state == S_IDLE);
  assign w_col          = bus.cmd_data[8];
  assign w_col_full     = w_col ? (r_wcnt1 == W_FULL) : (r_wcnt0 == W_FULL);
  assign w_weights_full = (r_wcnt0 == W_FULL) & (r_wcnt1 == W_FULL);
  assign w_weight_ok    = w_accept & w_in_idle & (bus.cmd_op == OP_WEIGHT) & ~w_col_full;
  assign w_act_ok       = w_accept & w_in_idle & (bus.cmd_op == OP_ACT) & (r_act_cnt != A_FULL);
  assign w_run_ok       = w_accept & w_in_idle & (bus.cmd_op == OP_RUN) & w_weights_full
                          & (r_act_cnt != '0);
  // cmd_ready is only high in IDLE and ERR, so any accepted FLUSH is legal
  assign w_flush        = w_accept & (bus.cmd_op == OP_FLUSH);
  assign w_drop         = w_accept & ~(w_weight_ok | w_act_ok | w_run_ok | w_flush);
  assign w_lc_rise      = bus.layer_complete & ~r_lc_d;
  assign w_wait_inc     = r_wait_cnt + TCW'(1);
  // completion on the same cycle as the limit takes priority over timeout
  assign w_timeout      = (r_state == S_WAIT_CPL) & ~w_lc_rise & (w_wait_inc == T_LIMIT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_run_ok) w_state_next = S_START;
      S_START:     if (bus.mlp_state == MLP_LOAD) w_state_next = S_WAIT_CPL;
      S_WAIT_CPL:  if (w_lc_rise) w_state_next = S_WAIT_IDLE;
                   else if (w_timeout) w_state_next = S_ERR;
      S_WAIT_IDLE: if (bus.mlp_state == MLP_IDLE) w_state_next = S_IDLE;
      S_ERR:       if (w_flush) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Output / counter next values (all registered below)
  always_comb begin
    w_done          = (r_state == S_WAIT_IDLE) & (bus.mlp_state == MLP_IDLE);
    w_push0         = w_weight_ok & ~w_col;
    w_push1         = w_weight_ok & w_col;
    w_wf_data       = w_weight_ok ? bus.cmd_data[7:0] : r_wf_data;
    w_act_valid     = w_act_ok;
    w_act_data      = w_act_ok ? bus.cmd_data : r_act_data;
    w_wf_reset      = w_flush | w_timeout;
    w_err_order     = w_drop;
    w_err_timeout   = w_timeout ? 1'b1 : (w_flush ? 1'b0 : r_err_timeout);
    w_start         = (w_state_next == S_START);
    w_busy          = (w_state_next != S_IDLE);
    w_cmd_ready     = (w_state_next == S_IDLE) | (w_state_next == S_ERR);
    w_wait_cnt      = (r_state == S_WAIT_CPL) ? w_wait_inc : '0;
    w_wcnt0         = r_wcnt0;
    w_wcnt1         = r_wcnt1;
    w_act_cnt       = r_act_cnt;
    if (w_flush | w_done) begin
      w_wcnt0   = '0;
      w_wcnt1   = '0;
      w_act_cnt = '0;
    end else begin
      if (w_push0)   w_wcnt0   = r_wcnt0 + WCW'(1);
      if (w_push1)   w_wcnt1   = r_wcnt1 + WCW'(1);
      if (w_act_ok)  w_act_cnt = r_act_cnt + ACW'(1);
    end
    w_weights_ready = (w_wcnt0 == W_FULL) & (w_wcnt1 == W_FULL);
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ready <= 1'b0;  r_push0 <= 1'b0;      r_push1 <= 1'b0;
      r_wf_reset  <= 1'b0;  r_act_valid <= 1'b0;  r_start <= 1'b0;
      r_weights_ready <= 1'b0;  r_busy <= 1'b0;   r_done <= 1'b0;
      r_err_order <= 1'b0;  r_err_timeout <= 1'b0;
      r_wf_data   <= '0;    r_act_data <= '0;
      r_wcnt0     <= '0;    r_wcnt1 <= '0;        r_act_cnt <= '0;
      r_wait_cnt  <= '0;    r_lc_d <= 1'b0;
    end else begin
      r_cmd_ready <= w_cmd_ready;  r_push0 <= w_push0;          r_push1 <= w_push1;
      r_wf_reset  <= w_wf_reset;   r_act_valid <= w_act_valid;  r_start <= w_start;
      r_weights_ready <= w_weights_ready;  r_busy <= w_busy;    r_done <= w_done;
      r_err_order <= w_err_order;  r_err_timeout <= w_err_timeout;
      r_wf_data   <= w_wf_data;    r_act_data <= w_act_data;
      r_wcnt0     <= w_wcnt0;      r_wcnt1 <= w_wcnt1;          r_act_cnt <= w_act_cnt;
      r_wait_cnt  <= w_wait_cnt;   r_lc_d <= bus.layer_complete;
    end
  end

`ifdef MLP_SEQ_PERF_CNT_EN
  logic        r_start_d;
  logic [15:0] r_perf_cnt, r_run_cycles;
  // Run timer: loads 1 at the end of the start_mlp rise cycle (so it reads
  // cycles-since-rise), saturates, and is sampled on layer_complete rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_d    <= 1'b0;
      r_perf_cnt   <= '0;
      r_run_cycles <= '0;
    end else begin
      r_start_d <= r_start;
      if (r_start & ~r_start_d)       r_perf_cnt <= 16'd1;
      else if (r_perf_cnt != 16'hFFFF) r_perf_cnt <= r_perf_cnt + 16'd1;
      if (w_lc_rise) r_run_cycles <= r_perf_cnt;
    end
  end
  assign bus.run_cycles = r_run_cycles;
`else
  assign bus.run_cycles = 16'd0;
`endif

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.wf_push_col0   = r_push0;
  assign bus.wf_push_col1   = r_push1;
  assign bus.wf_data_in     = r_wf_data;
  assign bus.wf_reset       = r_wf_reset;
  assign bus.init_act_valid = r_act_valid;
  assign bus.init_act_data  = r_act_data;
  assign bus.start_mlp      = r_start;
  assign bus.weights_ready  = r_weights_ready;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.err_order      = r_err_order;
  assign bus.err_timeout    = r_err_timeout;
endmodule

// File: tb/tb_mlp_run_sequencer.sv
// Self-checking bench for mlp_run_sequencer: directed vector table,
// hand-written timeout / async-reset sequences, and randomized commands
// checked against a count-based model of the command rules.
`timescale 1ns/1ps
module tb_mlp_run_sequencer;
  localparam int WPC     = 2;
  localparam int MAXA    = 8;
  localparam int TIMEOUT = 255;

  // flag vector bit positions: {push0,push1,act_valid,wf_reset,start,err_order,weights_ready,busy,done,cmd_ready}
  localparam logic [9:0] F_P0  = 10'h200;
  localparam logic [9:0] F_P1  = 10'h100;
  localparam logic [9:0] F_AV  = 10'h080;
  localparam logic [9:0] F_WR  = 10'h040;
  localparam logic [9:0] F_ST  = 10'h020;
  localparam logic [9:0] F_EO  = 10'h010;
  localparam logic [9:0] F_RDY = 10'h008;
  localparam logic [9:0] F_BSY = 10'h004;
  localparam logic [9:0] F_DN  = 10'h002;
  localparam logic [9:0] F_CR  = 10'h001;
  localparam logic [9:0] F_PULSE = F_P0 | F_P1 | F_AV | F_WR | F_EO | F_DN;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [9:0]  flags;
    logic [15:0] dval;
  } vec_t;

  vec_t tbl [11];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   m_w0, m_w1, m_act;
  logic [9:0] w_flags;

  mlp_run_sequencer_if bus();
  mlp_run_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign w_flags = {bus.wf_push_col0, bus.wf_push_col1, bus.init_act_valid, bus.wf_reset,
                    bus.start_mlp, bus.err_order, bus.weights_ready, bus.busy,
                    bus.done, bus.cmd_ready};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Present one command at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [15:0] data);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    $display("txn op=%0d data=%h flags=%b", op, data, w_flags);
  endtask

  // Command rules expressed on plain counts.
  task automatic model_cmd(input logic [1:0] op, input logic [15:0] data,
                           output logic [9:0] ef, output logic [15:0] ed);
    ef = F_CR;
    ed = 16'h0;
    case (op)
      2'd0: begin
        if (data[8]) begin
          if (m_w1 < WPC) begin m_w1++; ef |= F_P1; ed = {8'h00, data[7:0]}; end
          else ef |= F_EO;
        end else begin
          if (m_w0 < WPC) begin m_w0++; ef |= F_P0; ed = {8'h00, data[7:0]}; end
          else ef |= F_EO;
        end
      end
      2'd1: begin
        if (m_act < MAXA) begin m_act++; ef |= F_AV; ed = data; end
        else ef |= F_EO;
      end
      2'd2: begin
        if (m_w0 == WPC && m_w1 == WPC && m_act > 0) ef = F_ST | F_BSY;
        else ef |= F_EO;
      end
      default: begin
        m_w0 = 0; m_w1 = 0; m_act = 0;
        ef |= F_WR;
      end
    endcase
    if (m_w0 == WPC && m_w1 == WPC) ef |= F_RDY;
  endtask

  task automatic apply(input logic [1:0] op, input logic [15:0] data,
                       input logic [9:0] ef, input logic [15:0] ed);
    issue(op, data);
    chk("flags", w_flags, ef);
    if ((ef & (F_P0 | F_P1)) != 0) chk("wf_data_in", bus.wf_data_in, ed[7:0]);
    if ((ef & F_AV) != 0)          chk("init_act_data", bus.init_act_data, ed);
    if ((ef & F_ST) == 0) begin
      @(negedge clk);
      chk("pulse_clear", w_flags, ef & ~F_PULSE);
    end
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [15:0] data);
    logic [9:0]  ef;
    logic [15:0] ed;
    model_cmd(op, data, ef, ed);
    apply(op, data, ef, ed);
  endtask

  task automatic load_all();
    model_apply(2'd3, 16'h0);
    model_apply(2'd0, 16'h0011);
    model_apply(2'd0, 16'h0022);
    model_apply(2'd0, 16'h0133);
    model_apply(2'd0, 16'h0144);
    model_apply(2'd1, 16'hBEEF);
  endtask

  // Plays mlp_top through one run after a legal RUN was accepted at cycle s.
  task automatic run_mlp(input int d_ack, input int d_lc, input int d_idle, input int s);
    int l;
    int exp_rc;
    repeat (d_ack) begin
      @(negedge clk);
      chk("start_hold", {bus.start_mlp, bus.busy}, 2'b11);
    end
    bus.mlp_state = 4'd1;
    @(negedge clk);
    chk("start_drop", {bus.start_mlp, bus.busy, bus.cmd_ready}, 3'b010);
    bus.mlp_state = 4'd3;
    repeat (d_lc) begin
      @(negedge clk);
      chk("wait_cpl", {bus.start_mlp, bus.done, bus.busy}, 3'b001);
    end
    bus.layer_complete = 1'b1;
    l = cyc;
    @(negedge clk);
`ifdef MLP_SEQ_PERF_CNT_EN
    exp_rc = l - s;
`else
    exp_rc = 0;
`endif
    chk("run_cycles", bus.run_cycles, exp_rc);
    chk("cpl_busy", {bus.busy, bus.done}, 2'b10);
    bus.mlp_state = 4'd8;
    repeat (d_idle) begin
      @(negedge clk);
      chk("wait_idle", {bus.busy, bus.done}, 2'b10);
    end
    bus.mlp_state = 4'd0;
    bus.layer_complete = 1'b0;
    @(negedge clk);
    chk("done_pulse", {bus.done, bus.busy, bus.cmd_ready, bus.weights_ready}, 4'b1010);
    @(negedge clk);
    chk("done_clear", bus.done, 0);
    m_w0 = 0; m_w1 = 0; m_act = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [15:0] d;
    logic [9:0]  ef;
    logic [15:0] ed;
    int s, a, seen, r;

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_data = 16'h0;
    bus.mlp_state = 4'd0; bus.layer_complete = 1'b0;
    m_w0 = 0; m_w1 = 0; m_act = 0;

    repeat (3) @(negedge clk);
    chk("reset_flags", {w_flags, bus.err_timeout}, 0);
    chk("reset_data", {bus.wf_data_in, bus.init_act_data}, 0);
    chk("reset_run_cycles", bus.run_cycles, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", w_flags, F_CR);

    // directed vector table: loading, order errors, full column
    tbl[0]  = '{2'd0, 16'h0001, F_P0 | F_CR,               16'h0001};
    tbl[1]  = '{2'd2, 16'h0000, F_EO | F_CR,               16'h0000};
    tbl[2]  = '{2'd0, 16'h0002, F_P0 | F_CR,               16'h0002};
    tbl[3]  = '{2'd0, 16'h00AA, F_EO | F_CR,               16'h0000};
    tbl[4]  = '{2'd0, 16'h0103, F_P1 | F_CR,               16'h0003};
    tbl[5]  = '{2'd2, 16'h0000, F_EO | F_CR,               16'h0000};
    tbl[6]  = '{2'd0, 16'h0104, F_P1 | F_RDY | F_CR,       16'h0004};
    tbl[7]  = '{2'd0, 16'h01EE, F_EO | F_RDY | F_CR,       16'h0000};
    tbl[8]  = '{2'd2, 16'h0000, F_EO | F_RDY | F_CR,       16'h0000};
    tbl[9]  = '{2'd1, 16'h0201, F_AV | F_RDY | F_CR,       16'h0201};
    tbl[10] = '{2'd2, 16'h0000, F_ST | F_RDY | F_BSY,      16'h0000};
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].op, tbl[i].data, tbl[i].flags, tbl[i].dval);
    end
    s = cyc;
    run_mlp(2, 10, 1, s);

    // timeout, ERR command filtering, FLUSH recovery
    load_all();
    model_apply(2'd2, 16'h0);
    bus.mlp_state = 4'd1;
    a = cyc;
    seen = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.err_timeout === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    chk("timeout_cycle", seen, a + 1 + TIMEOUT);
    chk("timeout_flags", w_flags & ~F_RDY, F_WR | F_BSY | F_CR);
    bus.mlp_state = 4'd0;
    @(negedge clk);
    chk("timeout_sticky", {bus.err_timeout, bus.wf_reset, bus.busy, bus.cmd_ready}, 4'b1011);
    issue(2'd1, 16'h1234);
    chk("err_state_act", {bus.err_order, bus.init_act_valid, bus.err_timeout}, 3'b101);
    model_apply(2'd3, 16'h0);
    chk("flush_clears_timeout", {bus.err_timeout, bus.busy}, 2'b00);

    // asynchronous reset in the middle of WAIT_CPL
    load_all();
    model_apply(2'd2, 16'h0);
    bus.mlp_state = 4'd1;
    @(negedge clk);
    bus.mlp_state = 4'd3;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_reset_flags", {w_flags, bus.err_timeout}, 0);
    chk("async_reset_data", {bus.wf_data_in, bus.init_act_data}, 0);
    chk("async_reset_run_cycles", bus.run_cycles, 0);
    bus.mlp_state = 4'd0;
    @(negedge clk);
    reset_n = 1'b1;
    m_w0 = 0; m_w1 = 0; m_act = 0;
    @(negedge clk);
    chk("post_reset_flags", w_flags, F_CR);
    model_apply(2'd2, 16'h0);

    // randomized command stream against the count model
    for (int i = 0; i < 160; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      d  = 16'($urandom);
      model_cmd(op, d, ef, ed);
      apply(op, d, ef, ed);
      if ((ef & F_ST) != 0) begin
        s = cyc;
        run_mlp($urandom_range(0, 3), $urandom_range(1, 20), $urandom_range(0, 3), s);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
